// File: rtl/bus_xfer_sequencer_if.sv
// Request handshake and strobe bundle for bus_xfer_sequencer.
// master = request issuer, slave = sequencer.
interface bus_xfer_sequencer_if;
  logic        req_valid;
  logic [4:0]  req_src;
  logic [4:0]  req_dst;
  logic        req_ready;
  logic [23:0] src_out;
  logic [23:0] dst_in;
  logic        busy;
  logic        done;
  logic        err;

  modport master (
    output req_valid, req_src, req_dst,
    input  req_ready, src_out, dst_in,
    input  busy, done, err
  );

  modport slave (
    input  req_valid, req_src, req_dst,
    output req_ready, src_out, dst_in,
    output busy, done, err
  );
endinterface

// File: rtl/bus_xfer_sequencer.sv
// Queued register-transfer sequencer: DRIVE/LOAD one-hot bus strobes.
// Optional request checking enabled by BUS_XFER_CHECK_EN.
module bus_xfer_sequencer #(
  parameter int DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 clr,
  bus_xfer_sequencer_if.slave  bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    LOAD
  } state_t;

  typedef struct packed {
    logic [4:0] src;
    logic [4:0] dst;
  } xfer_t;

  xfer_t         r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  state_t        r_state;
  xfer_t         r_cur;
  logic [23:0]   r_src_out;
  logic [23:0]   r_dst_in;
  logic          r_busy;
  logic          r_done;
  logic          r_err;

  logic          w_ready;
  logic          w_acc;
  logic          w_bad;
  logic          w_push;
  logic          w_pop;
  xfer_t         w_req;
  xfer_t         w_head;
  logic [CW-1:0] w_count_nxt;
  state_t        w_state_nxt;
  logic          w_busy_nxt;

  // Code k maps to bit 23-k; codes past C give an empty vector
  function automatic logic [23:0] f_onehot(input logic [4:0] k);
    f_onehot = (k < 5'd24) ? (24'h800000 >> k) : 24'h0;
  endfunction

  assign w_ready = (r_count < CW'(DEPTH));
  assign w_acc   = bus.req_valid && w_ready;
  assign w_req   = '{src: bus.req_src, dst: bus.req_dst};
  assign w_head  = r_mem[r_rptr];

`ifdef BUS_XFER_CHECK_EN
  // PC loads only through its increment path; InPort is read-only
  assign w_bad = (bus.req_src > 5'd23) || (bus.req_dst > 5'd23) ||
                 (bus.req_dst == 5'd22) || (bus.req_dst == 5'd20);
`else
  assign w_bad = 1'b0;
`endif

  assign w_push      = w_acc && !w_bad;
  assign w_pop       = (r_count != '0) && (r_state != DRIVE);
  assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

  always_comb begin
    w_state_nxt = IDLE;
    if (r_state == DRIVE) w_state_nxt = LOAD;
    else if (w_pop)       w_state_nxt = DRIVE;
  end

  assign w_busy_nxt = (w_state_nxt != IDLE) || (w_count_nxt != '0);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_req;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_count <= w_count_nxt;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state   <= IDLE;
      r_cur     <= '0;
      r_src_out <= '0;
      r_dst_in  <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= 1'b0;
      r_err   <= w_acc && w_bad;
      unique case (r_state)
        DRIVE: begin
          r_dst_in <= f_onehot(r_cur.dst);
          r_done   <= 1'b1;
        end
        default: begin
          if (w_pop) begin
            r_cur     <= w_head;
            r_src_out <= f_onehot(w_head.src);
          end else begin
            r_src_out <= '0;
          end
          r_dst_in <= '0;
        end
      endcase
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.src_out   = r_src_out;
  assign bus.dst_in    = r_dst_in;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.err       = r_err;

endmodule

// File: tb/tb_bus_xfer_sequencer.sv
// Scoreboard bench for bus_xfer_sequencer.
// Honours BUS_XFER_CHECK_EN when compiled with it.
module tb_bus_xfer_sequencer;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  bus_xfer_sequencer_if bus ();

  bus_xfer_sequencer #(.DEPTH(2)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  logic [47:0] exp_q [$];
  int          done_cyc [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [47:0] act,
                     input logic [47:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [23:0] exp_vec(input logic [4:0] k);
    logic [23:0] one;
    one = 24'h1;
    exp_vec = (k > 5'd23) ? 24'h0 : (one << (5'd23 - k));
  endfunction

  function automatic bit tb_reject(input logic [4:0] s,
                                   input logic [4:0] d);
`ifdef BUS_XFER_CHECK_EN
    tb_reject = (s > 23) || (d > 23) || (d == 22) || (d == 20);
`else
    tb_reject = 1'b0;
`endif
  endfunction

  // Monitor: per-cycle strobe legality plus scoreboard pop on done
  always @(negedge clk) begin
    logic [47:0] e;
    if (clr === 1'b1) begin
      chk("src_onehot0", 48'($onehot0(bus.src_out)), 48'd1);
      chk("dst_onehot0", 48'($onehot0(bus.dst_in)), 48'd1);
      if (bus.src_out != 0 && !bus.done)
        chk("drive_dst_zero", 48'(bus.dst_in), 48'd0);
`ifndef BUS_XFER_CHECK_EN
      chk("err_tied_low", 48'(bus.err), 48'd0);
`endif
      if (bus.done) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_done: got done=1 expected no transfer");
        end else begin
          e = exp_q.pop_front();
          chk("xfer", {bus.src_out, bus.dst_in}, e);
          done_cyc.push_back(cyc);
        end
      end
    end
  end

  task automatic send(input logic [4:0] s, input logic [4:0] d,
                      input logic [23:0] es, input logic [23:0] ed,
                      input bit rej);
    int n;
    n = 0;
    bus.req_valid = 1'b1;
    bus.req_src   = s;
    bus.req_dst   = d;
    while (!bus.req_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 50) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: got req_ready=0 expected 1");
      bus.req_valid = 1'b0;
    end else begin
      if (!rej) exp_q.push_back({es, ed});
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.busy) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got pending=%0d expected 0",
               exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [4:0] s;
    logic [4:0] d;
    int         nd;
    clr           = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_src   = '0;
    bus.req_dst   = '0;

    @(posedge clk);
    #1;
    chk("rst_src", 48'(bus.src_out), 48'd0);
    chk("rst_dst", 48'(bus.dst_in), 48'd0);
    chk("rst_flags", {44'd0, bus.done, bus.err, bus.busy, bus.req_ready},
        48'b0001);
    @(posedge clk);
    #1;
    clr = 1'b1;
    @(posedge clk);
    #1;

    // single R4 -> HI
    send(5'd4, 5'd16, 24'h080000, 24'h000080, 1'b0);
    chk("t1_e0_busy", 48'(bus.busy), 48'd1);
    chk("t1_e0_src", 48'(bus.src_out), 48'd0);
    @(posedge clk);
    #1;
    chk("t1_e1", {bus.src_out, bus.dst_in}, {24'h080000, 24'h000000});
    chk("t1_e1_done", 48'(bus.done), 48'd0);
    @(posedge clk);
    #1;
    chk("t1_e2", {bus.src_out, bus.dst_in}, {24'h080000, 24'h000080});
    chk("t1_e2_done", 48'(bus.done), 48'd1);
    @(posedge clk);
    #1;
    chk("t1_e3", {bus.src_out, bus.dst_in}, 48'd0);
    chk("t1_e3_flags", {46'd0, bus.busy, bus.done}, 48'd0);
    drain();

    // back-to-back R1->R2, MDR->R3, R3->Zlow
    done_cyc.delete();
    send(5'd1, 5'd2, 24'h400000, 24'h200000, 1'b0);
    send(5'd21, 5'd3, 24'h000004, 24'h100000, 1'b0);
    chk("pp_ready_cnt1", 48'(bus.req_ready), 48'd1);
    send(5'd3, 5'd19, 24'h100000, 24'h000010, 1'b0);
    chk("b2b_full_ready", 48'(bus.req_ready), 48'd0);
    drain();
    nd = done_cyc.size();
    chk("b2b_done_count", 48'(nd), 48'd3);
    if (nd == 3) begin
      chk("b2b_gap1", 48'(done_cyc[1] - done_cyc[0]), 48'd2);
      chk("b2b_gap2", 48'(done_cyc[2] - done_cyc[1]), 48'd2);
    end

    // reset during LOAD with one request still queued
    send(5'd5, 5'd6, 24'h040000, 24'h020000, 1'b0);
    send(5'd7, 5'd8, 24'h010000, 24'h008000, 1'b0);
    @(posedge clk);
    #2;
    chk("rst_pre_done", 48'(bus.done), 48'd1);
    chk("rst_pre_dst", 48'(bus.dst_in), 48'h020000);
    clr = 1'b0;
    #1;
    chk("rst_async_strobes", {bus.src_out, bus.dst_in}, 48'd0);
    chk("rst_async_flags", {46'd0, bus.done, bus.busy}, 48'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    clr = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("rst_after_busy", 48'(bus.busy), 48'd0);
    chk("rst_after_ready", 48'(bus.req_ready), 48'd1);

    // out-of-range source code
`ifdef BUS_XFER_CHECK_EN
    send(5'd27, 5'd5, 24'h0, 24'h0, 1'b1);
    chk("bad_err", 48'(bus.err), 48'd1);
    chk("bad_busy", 48'(bus.busy), 48'd0);
    chk("bad_src", 48'(bus.src_out), 48'd0);
    @(posedge clk);
    #1;
    chk("bad_err_clear", 48'(bus.err), 48'd0);
    chk("bad_busy_after", 48'(bus.busy), 48'd0);
`else
    send(5'd27, 5'd5, 24'h0, 24'h040000, 1'b0);
    chk("oor_err", 48'(bus.err), 48'd0);
    chk("oor_busy", 48'(bus.busy), 48'd1);
`endif
    drain();

    // random run
    for (int i = 0; i < 200; i++) begin
      s = 5'($urandom_range(0, 31));
      d = 5'($urandom_range(0, 31));
      send(s, d, exp_vec(s), exp_vec(d), tb_reject(s, d));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    drain();
    chk("final_idle", {46'd0, bus.busy, bus.req_ready}, 48'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
